// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command frame parser.
// Status codes travel in the third byte of every response frame.
package uart_cmd_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SOF,
    ST_OPC,
    ST_LEN,
    ST_PAY,
    ST_CSUM,
    ST_DRAIN,
    ST_ISSUE,
    ST_RESP
  } state_t;

  localparam logic [7:0] STS_OK    = 8'h00;
  localparam logic [7:0] STS_CSUM  = 8'h01;
  localparam logic [7:0] STS_LEN   = 8'h02;
  localparam logic [7:0] STS_TRUNC = 8'h03;

  localparam logic [7:0] DEFAULT_SOF = 8'hA5;
  localparam logic [7:0] DEFAULT_RSP = 8'h5A;

  function automatic logic [7:0] sat_inc(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/uart_cmd_resp.sv
// Three-byte response serializer into the UART TX FIFO.
// A start pulse arms it; it stalls while the FIFO is full and pulses done on the last push.
module uart_cmd_resp (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       tx_fifo_full,
  input  logic [7:0] byte0,
  input  logic [7:0] byte1,
  input  logic [7:0] byte2,
  output logic       tx_fifo_write_en,
  output logic [7:0] tx_fifo_data,
  output logic       done
);

  logic       busy_reg;
  logic [1:0] idx_reg;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      busy_reg <= 1'b0;
      idx_reg  <= 2'd0;
    end else if (start) begin
      busy_reg <= 1'b1;
      idx_reg  <= 2'd0;
    end else if (busy_reg && !tx_fifo_full) begin
      if (idx_reg == 2'd2) begin
        busy_reg <= 1'b0;
        idx_reg  <= 2'd0;
      end else begin
        idx_reg <= idx_reg + 2'd1;
      end
    end
  end

  always_comb begin
    tx_fifo_write_en = busy_reg && !tx_fifo_full;
    done             = tx_fifo_write_en && (idx_reg == 2'd2);
    tx_fifo_data     = 8'h00;
    if (busy_reg) begin
      case (idx_reg)
        2'd0:    tx_fifo_data = byte0;
        2'd1:    tx_fifo_data = byte1;
        default: tx_fifo_data = byte2;
      endcase
    end
  end

endmodule

// File: rtl/uart_cmd_parser.sv
// Drains a framed command (SOF, OPC, LEN, PAYLOAD, CSUM) from the UART RX FIFO,
// hands good commands to the core and answers every non-silent frame with a status response.
module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter int         MAX_PAYLOAD = 8,
  parameter logic [7:0] SOF_BYTE    = DEFAULT_SOF,
  parameter logic [7:0] RSP_BYTE    = DEFAULT_RSP
) (
  input  logic                     clock,
  input  logic                     reset,   // asynchronous, active-low
  input  logic                     packet_received,
  input  logic                     rx_fifo_empty,
  input  logic [7:0]               rx_fifo_data,
  output logic                     rx_fifo_read_en,
  input  logic                     tx_fifo_full,
  output logic [7:0]               tx_fifo_data,
  output logic                     tx_fifo_write_en,
  output logic                     cmd_valid,
  input  logic                     cmd_ready,
  output logic [7:0]               cmd_opcode,
  output logic [7:0]               cmd_length,
  output logic [MAX_PAYLOAD*8-1:0] cmd_payload,
  output logic [7:0]               error_count
);

  localparam logic [7:0] MAX_LEN = 8'(MAX_PAYLOAD);

  state_t     state_reg, state_next;
  logic       pending_reg, pending_next;
  logic       silent_reg, silent_next;
  logic [7:0] status_reg, status_next;
  logic [7:0] opc_reg, opc_next;
  logic [7:0] len_reg, len_next;
  logic [7:0] count_reg, count_next;
  logic [7:0] csum_reg, csum_next;
  logic [7:0] err_reg, err_next;
  logic       clear_payload;
  logic       store_payload;
  logic       resp_start;
  logic       resp_done;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg   <= ST_IDLE;
      pending_reg <= 1'b0;
      silent_reg  <= 1'b0;
      status_reg  <= STS_OK;
      opc_reg     <= 8'h00;
      len_reg     <= 8'h00;
      count_reg   <= 8'h00;
      csum_reg    <= 8'h00;
      err_reg     <= 8'h00;
    end else begin
      state_reg   <= state_next;
      pending_reg <= pending_next;
      silent_reg  <= silent_next;
      status_reg  <= status_next;
      opc_reg     <= opc_next;
      len_reg     <= len_next;
      count_reg   <= count_next;
      csum_reg    <= csum_next;
      err_reg     <= err_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    pending_next    = pending_reg;
    silent_next     = silent_reg;
    status_next     = status_reg;
    opc_next        = opc_reg;
    len_next        = len_reg;
    count_next      = count_reg;
    csum_next       = csum_reg;
    err_next        = err_reg;
    rx_fifo_read_en = 1'b0;
    clear_payload   = 1'b0;
    store_payload   = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (pending_reg) begin
          state_next    = ST_SOF;
          pending_next  = 1'b0;
          clear_payload = 1'b1;
          silent_next   = 1'b0;
          status_next   = STS_OK;
          opc_next      = 8'h00;
          len_next      = 8'h00;
          count_next    = 8'h00;
          csum_next     = 8'h00;
        end
      end
      ST_SOF, ST_OPC, ST_LEN, ST_PAY, ST_CSUM: begin
        rx_fifo_read_en = !rx_fifo_empty;
        if (rx_fifo_empty) begin
          status_next = STS_TRUNC;
          state_next  = ST_RESP;
        end else begin
          case (state_reg)
            ST_SOF: begin
              if (rx_fifo_data != SOF_BYTE) begin
                silent_next = 1'b1;
                state_next  = ST_DRAIN;
              end else begin
                state_next = ST_OPC;
              end
            end
            ST_OPC: begin
              opc_next   = rx_fifo_data;
              csum_next  = rx_fifo_data;
              state_next = ST_LEN;
            end
            ST_LEN: begin
              len_next  = rx_fifo_data;
              csum_next = csum_reg ^ rx_fifo_data;
              if (rx_fifo_data > MAX_LEN) begin
                status_next = STS_LEN;
                state_next  = ST_DRAIN;
              end else if (rx_fifo_data == 8'h00) begin
                state_next = ST_CSUM;
              end else begin
                state_next = ST_PAY;
              end
            end
            ST_PAY: begin
              store_payload = 1'b1;
              csum_next     = csum_reg ^ rx_fifo_data;
              count_next    = count_reg + 8'd1;
              if (count_reg == len_reg - 8'd1) begin
                state_next = ST_CSUM;
              end
            end
            default: begin
              status_next = (rx_fifo_data == csum_reg) ? STS_OK : STS_CSUM;
              state_next  = ST_DRAIN;
            end
          endcase
        end
      end
      ST_DRAIN: begin
        if (!rx_fifo_empty) begin
          rx_fifo_read_en = 1'b1;
          if (status_reg == STS_OK) begin
            status_next = STS_TRUNC;
          end
        end else if (silent_reg) begin
          // Silent wins: a lone bad header leaves status at OK but must not issue.
          state_next = ST_IDLE;
        end else if (status_reg == STS_OK) begin
          state_next = ST_ISSUE;
        end else begin
          state_next = ST_RESP;
        end
      end
      ST_ISSUE: begin
        if (cmd_ready) begin
          state_next = ST_RESP;
        end
      end
      ST_RESP: begin
        if (resp_done) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    // A new pulse outranks the clear on SOF entry so it is never lost.
    if (packet_received) begin
      pending_next = 1'b1;
    end

    // Every frame without a handshake ends either in RESP with an error status or silently in IDLE.
    if ((state_next == ST_RESP && state_reg != ST_RESP && state_reg != ST_ISSUE) ||
        (state_reg == ST_DRAIN && state_next == ST_IDLE)) begin
      err_next = sat_inc(err_reg);
    end
  end

  assign resp_start = (state_next == ST_RESP) && (state_reg != ST_RESP);

  genvar gi;
  generate
    for (gi = 0; gi < MAX_PAYLOAD; gi++) begin : g_payload
      logic [7:0] byte_reg;
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          byte_reg <= 8'h00;
        end else if (clear_payload) begin
          byte_reg <= 8'h00;
        end else if (store_payload && count_reg == 8'(gi)) begin
          byte_reg <= rx_fifo_data;
        end
      end
      assign cmd_payload[gi*8 +: 8] = byte_reg;
    end
  endgenerate

  uart_cmd_resp u_resp (
    .clock            (clock),
    .reset            (reset),
    .start            (resp_start),
    .tx_fifo_full     (tx_fifo_full),
    .byte0            (RSP_BYTE),
    .byte1            (opc_reg),
    .byte2            (status_reg),
    .tx_fifo_write_en (tx_fifo_write_en),
    .tx_fifo_data     (tx_fifo_data),
    .done             (resp_done)
  );

  assign cmd_valid   = (state_reg == ST_ISSUE);
  assign cmd_opcode  = opc_reg;
  assign cmd_length  = len_reg;
  assign error_count = err_reg;

endmodule
